// File: rtl/async_fifo_stream_reader.sv
// Read-domain drain engine: pulls words from async_fifo into a 3-entry prefetch buffer and
// presents them as a framed valid/ready stream. Optional FIFO_READER_WORD_CNT_EN adds word_count.
module async_fifo_stream_reader #(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned PKT_LEN = 16
) (
    input  logic             rd_clk,
    input  logic             rd_rst,
    input  logic             enable,
    input  logic             fifo_empty,
    input  logic [WIDTH-1:0] fifo_dout,
    output logic             fifo_rd_en,
    output logic [WIDTH-1:0] m_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic             m_last,
`ifdef FIFO_READER_WORD_CNT_EN
    output logic [31:0]      word_count,
`endif
    output logic             busy
);

    localparam int unsigned BeatW = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
    localparam logic [BeatW-1:0] LastBeat = BeatW'(PKT_LEN - 1);

    logic [WIDTH-1:0] mem_q [3];
    logic [1:0]       head_q, head_d;
    logic [1:0]       tail_q, tail_d;
    logic [1:0]       occ_q, occ_d;
    logic             inflight_q;
    logic [BeatW-1:0] beat_q, beat_d;
    logic [2:0]       credit;
    logic             push, pop;

    function automatic logic [1:0] wrap_inc(input logic [1:0] p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

    // Credit counts words already buffered plus the one still on its way from the FIFO.
    always_comb begin
        credit     = {1'b0, occ_q} + {2'b00, inflight_q};
        fifo_rd_en = ~rd_rst & enable & ~fifo_empty & (credit < 3'd3);
    end

    always_comb begin
        m_valid = (occ_q != 2'd0);
        m_data  = mem_q[head_q];
        m_last  = (beat_q == LastBeat);
        busy    = (occ_q != 2'd0) | inflight_q;
        push    = inflight_q;
        pop     = m_valid & m_ready;
    end

    always_comb begin
        occ_d  = occ_q;
        head_d = head_q;
        tail_d = tail_q;
        beat_d = beat_q;
        if (push) begin
            tail_d = wrap_inc(tail_q);
        end
        if (pop) begin
            head_d = wrap_inc(head_q);
            beat_d = (beat_q == LastBeat) ? '0 : beat_q + BeatW'(1);
        end
        case ({push, pop})
            2'b10:   occ_d = occ_q + 2'd1;
            2'b01:   occ_d = occ_q - 2'd1;
            default: occ_d = occ_q;
        endcase
    end

    always_ff @(posedge rd_clk) begin
        if (rd_rst) begin
            // An in-flight word is dropped here; the FIFO has already advanced past it.
            occ_q      <= 2'd0;
            head_q     <= 2'd0;
            tail_q     <= 2'd0;
            inflight_q <= 1'b0;
            beat_q     <= '0;
            for (int i = 0; i < 3; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            occ_q      <= occ_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            inflight_q <= fifo_rd_en;
            beat_q     <= beat_d;
            if (push) begin
                mem_q[tail_q] <= fifo_dout;
            end
        end
    end

`ifdef FIFO_READER_WORD_CNT_EN
    always_ff @(posedge rd_clk) begin
        if (rd_rst) begin
            word_count <= 32'd0;
        end else if (pop) begin
            word_count <= word_count + 32'd1;
        end
    end
`endif

endmodule

// File: doc/async_fifo_stream_reader.md
# async_fifo_stream_reader

Read-side drain engine for the `async_fifo` block. It runs entirely in the FIFO read clock domain and issues `fifo_rd_en` only when the FIFO is non-empty. It absorbs the FIFO's one-cycle registered read latency in a 3-entry prefetch buffer. It presents the words as a valid/ready stream with packet framing (`m_last` every `PKT_LEN` beats) to downstream DSP/packetizer logic.

## Interface
- `WIDTH`, 32, data word width; must match the FIFO `WIDTH`.
- `PKT_LEN`, 16, beats per packet; legal range 1..65535.
- `rd_clk`  in  1  read-domain clock, the same clock as the FIFO `rd_clk`.
- `rd_rst`  in  1  reset, synchronous, active-high.
- `enable`  in  1  when 0, no new FIFO reads are issued; buffered words still drain.
- `fifo_empty`  in  1  FIFO `empty` flag.
- `fifo_dout`  in  WIDTH  FIFO `dout`; valid one cycle after `fifo_rd_en` is sampled.
- `fifo_rd_en`  out  WIDTH=1  read strobe to the FIFO.
- `m_data`  out  WIDTH  stream data, taken from the head of the buffer.
- `m_valid`  out  1  stream valid.
- `m_ready`  in  1  downstream ready.
- `m_last`  out  1  last beat of a packet; qualified by `m_valid`.
- `busy`  out  1  high when the buffer is non-empty or a read is in flight.

## Operation
- Internal state:
  - 3-entry circular buffer with 2-bit `occ` (0..3).
  - 1-bit `inflight`.
  - Beat counter `beat` of width $clog2(PKT_LEN) (minimum 1).
- Read issue: `fifo_rd_en = enable & ~fifo_empty & ((occ + inflight) < 3)`.
  - It is purely a function of registers and the FIFO flag. There is no combinational path from `m_ready`.
- `inflight <= fifo_rd_en`. When `inflight == 1`, `fifo_dout` is written to the buffer tail at that edge.
- Pop occurs when `m_valid & m_ready`. The head advances and `occ` decrements.
  - A simultaneous push and pop leaves `occ` unchanged.
- `m_valid = (occ != 0)`.
- Head/tail pointers wrap modulo 3. The credit rule guarantees a push never occurs when `occ == 3`.
- Framing:
  - `m_last = (beat == PKT_LEN-1)`.
  - `beat` increments on each pop and wraps to 0 after the `m_last` beat.
  - With `PKT_LEN == 1`, `m_last` is constantly 1.
- `busy = (occ != 0) | inflight`.
- Stream hold: while `m_valid & ~m_ready`, `m_data` and `m_last` hold stable.
- `enable` deasserted mid-stream: no new reads are issued. An in-flight word is still captured, and all buffered words drain normally.
- Reset mid-operation (`rd_rst == 1` at an edge):
  - `occ`, `inflight`, `beat`, and the pointers are cleared to 0.
  - Any in-flight word is discarded. The FIFO pointer has already advanced, so that word is lost by design.
  - `fifo_rd_en` is forced to 0 while `rd_rst` is high.
- Reset values: `fifo_rd_en=0`, `m_valid=0`, `m_last=0` (`beat=0`; `m_last` is 1 only if `PKT_LEN==1`), `m_data=0`, `busy=0`.

## Timing
- `fifo_empty` falls in cycle k with the buffer empty and `enable=1`:
  - `fifo_rd_en` is high in cycle k.
  - The word is on `fifo_dout` in cycle k+1 and is captured at the end of k+1.
  - `m_valid` is high in cycle k+2.
- Sustained throughput is 1 word/cycle when the FIFO stays non-empty and `m_ready=1`. Steady state is `occ=1` with `inflight=1`.
- With `m_ready=0`, at most 3 words are read before `fifo_rd_en` stops.
  - `fifo_rd_en` is high for exactly 3 cycles from the first issue.
- After `m_ready` rises, a new read is issued the cycle after the first pop.

## Configuration
- `FIFO_READER_WORD_CNT_EN` defined:
  - Adds output `word_count [31:0]`, which counts pops and wraps at 2^32.
  - Reset value is 0.
- Not defined: the port and its counter are absent; all other behaviour is identical.

## Test plan
- Reset, then the FIFO holds 8 words 0..7 with `m_ready=1` and `PKT_LEN=4` -> `m_data` 0..7 on consecutive cycles. `m_last` is high on words 3 and 7. `busy` falls 2 cycles after the final `fifo_rd_en`.
- The FIFO holds 10 words and `m_ready=0` -> exactly 3 `fifo_rd_en` pulses, `m_valid=1`, and `m_data=0` held stable. Releasing `m_ready` delivers 0..9 in order with no loss or duplicates.
- The FIFO is empty throughout -> `fifo_rd_en` is never asserted, and `m_valid=0` and `busy=0` at all times.
- `enable` drops after 2 reads have been issued -> both words are delivered, no further `fifo_rd_en` occurs, and `busy` returns to 0. Re-enabling resumes at the next FIFO word.
- `rd_rst` is pulsed while `occ=2` and `inflight=1` -> the next cycle shows `m_valid=0`, `busy=0`, `beat=0`. The next delivered word is the FIFO's fourth word, and its `m_last` position restarts from beat 0.
- Random `m_ready` (50%) over 200 incrementing words with `PKT_LEN=7` -> the sequence is in order and gap-free. `m_last` marks every 7th beat. `word_count=200` when `FIFO_READER_WORD_CNT_EN` is defined.
